// File: rtl/i2c_uart_bridge_if.sv
// rtl/i2c_uart_bridge_if.sv - I2C clock input and UART TX output bundle for i2c_uart_bridge
interface i2c_uart_bridge_if;
  logic i_SCL;
  logic o_TX;

  modport master (output i_SCL, input  o_TX);
  modport slave  (input  i_SCL, output o_TX);
endinterface

// File: rtl/i2c_uart_bridge.sv
// rtl/i2c_uart_bridge.sv - write-only I2C slave forwarding received bytes to a UART 8N1 transmitter
module i2c_uart_bridge #(
  parameter logic [6:0] I2C_ADDR     = 7'h47,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  i2c_uart_bridge_if.slave bus,
  inout  wire              io_SDA
);
  // FIFO_DEPTH is a power of two >= 2; pointers carry one extra wrap bit.
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic          scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic          scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          sda_oe_q, sda_oe_d;
  logic          push;
  logic [7:0]    rx_byte;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          fifo_full, fifo_empty;

  logic          tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          bit_end, pop;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q - rd_ptr_q) == FULL_CNT);

  // Open drain: only ever pull low or let go.
  assign io_SDA = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.o_TX = tx_q;

  // Two-flop synchronizers plus one delayed copy for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], bus.i_SCL};
    sda_sync_d = {sda_sync_q[0], io_SDA};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
  end

  // I2C slave: START/STOP override everything, bits shift in on SCL rise, ACK spans one SCL period.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sda_oe_d  = sda_oe_q;
    push      = 1'b0;
    rx_byte   = {shift_q[6:0], sda_s};
    if (start_det) begin
      state_d   = S_ADDR;
      shift_d   = '0;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_DATA: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              if (state_q == S_ADDR) begin
                state_d = (rx_byte == {I2C_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
              end else if (!fifo_full) begin
                push    = 1'b1;
                state_d = S_DATA_ACK;
              end else begin
                state_d = S_IGNORE;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          // First falling edge starts the ACK, the second one ends it.
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_DATA;
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  // Byte FIFO and UART framer; a pending byte is popped as the previous stop bit ends.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_d       = tx_q;
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    bit_end    = tx_busy_q && (tx_cnt_q == CNT_LAST);
    pop        = !fifo_empty && (!tx_busy_q || (bit_end && tx_bit_q == 4'd9));
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = rx_byte;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (tx_busy_q) begin
      tx_cnt_d = bit_end ? '0 : tx_cnt_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      tx_busy_d  = 1'b1;
      tx_d       = 1'b0;
      tx_shift_d = {1'b1, mem_q[rd_ptr_q[AW-1:0]]};
      tx_bit_d   = '0;
      tx_cnt_d   = '0;
    end else if (bit_end) begin
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_d      = 1'b1;
      end else begin
        tx_d       = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end
  end

  // State registers; synchronizers reset to the idle-high bus level so release makes no false edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_oe_q   <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_q       <= tx_d;
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end
endmodule

// File: tb/tb_i2c_uart_bridge.sv
// tb/tb_i2c_uart_bridge.sv - self-checking bench for i2c_uart_bridge
module tb_i2c_uart_bridge;
  localparam int         CPB    = 224;
  localparam int         DEPTH  = 4;
  localparam logic [6:0] ADDR   = 7'h47;
  localparam int         Q      = 10;
  localparam longint     CLK_NS = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda_low;
  wire  sda;

  i2c_uart_bridge_if bus ();

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_uart_bridge #(.I2C_ADDR(ADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus),
    .io_SDA   (sda)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  int         tot_accepted = 0;
  int         mon_starts  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_data[$];
  logic [9:0] rx_raw_q[$];
  longint     rx_t_q[$];

  // UART receiver: samples mid-bit, drops frames that overlap a reset.
  initial begin
    logic [9:0] raw;
    bit         ok;
    longint     t0;
    forever begin
      @(negedge bus.o_TX);
      if (rst_n !== 1'b1) continue;
      t0 = $time;
      mon_starts++;
      ok = 1'b1;
      raw = '0;
      repeat (CPB/2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        raw[i] = bus.o_TX;
        if (rst_n !== 1'b1) ok = 1'b0;
        if (i < 9) repeat (CPB) @(negedge clk);
      end
      if (ok) begin
        rx_raw_q.push_back(raw);
        rx_t_q.push_back(t0);
      end
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; qwait();
    bus.i_SCL = 1'b1; qwait();
    m_sda_low = 1'b1; qwait();
    bus.i_SCL = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; qwait();
    bus.i_SCL = 1'b1; qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic i2c_bit(input logic b);
    m_sda_low = !b; qwait();
    bus.i_SCL = 1'b1; qwait(); qwait();
    bus.i_SCL = 1'b0; qwait();
  endtask

  task automatic i2c_ack(output logic ack);
    m_sda_low = 1'b0; qwait();
    bus.i_SCL = 1'b1; qwait();
    ack = (sda === 1'b0); qwait();
    bus.i_SCL = 1'b0; qwait();
  endtask

  // Master write of wr_data; the model predicts each ACK from the FIFO occupancy it infers
  // (bytes accepted so far minus frames the UART has started).
  task automatic i2c_xfer(input logic [6:0] addr, input logic rw, input bit do_stop,
                          output logic addr_ack, output logic exp_addr_ack,
                          output logic [7:0] got_mask, output logic [7:0] exp_mask);
    logic [7:0] a, b;
    logic       k;
    bit         dead;
    a = {addr, rw};
    got_mask = '0;
    exp_mask = '0;
    exp_addr_ack = (addr == ADDR) && (rw == 1'b0);
    dead = !exp_addr_ack;
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(a[i]);
    i2c_ack(addr_ack);
    for (int j = 0; j < wr_data.size(); j++) begin
      b = wr_data[j];
      for (int i = 7; i >= 0; i--) i2c_bit(b[i]);
      if (!dead) begin
        if (tot_accepted - mon_starts < DEPTH) begin
          exp_mask[j] = 1'b1;
          tot_accepted++;
          exp_q.push_back(b);
        end else begin
          dead = 1'b1;
        end
      end
      i2c_ack(k);
      got_mask[j] = k;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic wait_frames(output bit timed_out);
    int budget;
    budget = (exp_q.size() + 1) * 11 * CPB + 200;
    while (rx_raw_q.size() < exp_q.size() && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    timed_out = (rx_raw_q.size() < exp_q.size());
    repeat (2*CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    logic       ka, ea, k;
    logic [7:0] gm, em, a;
    int         base;
    vectors++; if (bus.o_TX !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", bus.o_TX); end
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_sda: got %b want 1", sda); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    wr_data = '{8'h3C};
    i2c_xfer(ADDR, 1'b0, 1'b1, ka, ea, gm, em);
    vectors++; if (ka !== ea || gm !== em) begin miscompares++; $display("FAIL reset_pre_ack: got %b/%h want %b/%h", ka, gm, ea, em); end
    a = {ADDR, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) i2c_bit(a[i]);
    m_sda_low = 1'b0; qwait();
    bus.i_SCL = 1'b1; qwait();
    k = sda;
    vectors++; if (k !== 1'b0) begin miscompares++; $display("FAIL reset_ack_held: got %b want 0", k); end
    vectors++; if (mon_starts != tot_accepted || rx_raw_q.size() != 0) begin miscompares++; $display("FAIL reset_frame_in_flight: got %0d/%0d want %0d/0", mon_starts, rx_raw_q.size(), tot_accepted); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (sda !== 1'b1) begin miscompares++; $display("FAIL reset_async_sda: got %b want 1", sda); end
    vectors++; if (bus.o_TX !== 1'b1) begin miscompares++; $display("FAIL reset_async_tx: got %b want 1", bus.o_TX); end
    repeat (2*CPB) @(negedge clk);
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
    rst_n = 1'b1;
    base = mon_starts;
    repeat (12*CPB) @(negedge clk);
    vectors++; if (mon_starts != base || rx_raw_q.size() != 0) begin miscompares++; $display("FAIL reset_no_frame: got %0d starts want %0d", mon_starts, base); end
    tot_accepted = mon_starts;
  endtask

  task automatic test_single();
    logic       ka, ea;
    logic [7:0] gm, em;
    bit         to;
    wr_data = '{8'h67};
    i2c_xfer(ADDR, 1'b0, 1'b1, ka, ea, gm, em);
    vectors++; if (ka !== 1'b1) begin miscompares++; $display("FAIL single_addr_ack: got %b want 1", ka); end
    vectors++; if (gm !== 8'h01) begin miscompares++; $display("FAIL single_data_ack: got %h want 01", gm); end
    wait_frames(to);
    vectors++; if (to || rx_raw_q.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d want 1", rx_raw_q.size()); end
    vectors++; if (mon_starts != tot_accepted) begin miscompares++; $display("FAIL single_frames: got %0d want %0d", mon_starts, tot_accepted); end
    if (rx_raw_q.size() > 0) begin
      vectors++; if (rx_raw_q[0] !== 10'b1011001110) begin miscompares++; $display("FAIL single_bits: got %b want 1011001110", rx_raw_q[0]); end
    end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  task automatic test_back_to_back();
    logic       ka, ea;
    logic [7:0] gm, em;
    bit         to;
    wr_data = '{8'h67, 8'h14, 8'h1E};
    i2c_xfer(ADDR, 1'b0, 1'b1, ka, ea, gm, em);
    vectors++; if (ka !== ea || gm !== 8'h07 || gm !== em) begin miscompares++; $display("FAIL b2b_acks: got %b/%h want %b/%h", ka, gm, ea, em); end
    wait_frames(to);
    vectors++; if (to || rx_raw_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", rx_raw_q.size(), exp_q.size()); end
    vectors++; if (mon_starts != tot_accepted) begin miscompares++; $display("FAIL b2b_frames: got %0d want %0d", mon_starts, tot_accepted); end
    for (int i = 0; i < exp_q.size() && i < rx_raw_q.size(); i++) begin
      vectors++; if (rx_raw_q[i] !== {1'b1, exp_q[i], 1'b0}) begin miscompares++; $display("FAIL b2b_data[%0d]: got %b want %b", i, rx_raw_q[i], {1'b1, exp_q[i], 1'b0}); end
    end
    for (int i = 1; i < rx_t_q.size(); i++) begin
      vectors++; if (rx_t_q[i] - rx_t_q[i-1] != 10*CPB*CLK_NS) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, rx_t_q[i] - rx_t_q[i-1], 10*CPB*CLK_NS); end
    end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  task automatic test_bad_addr();
    logic       ka, ea;
    logic [7:0] gm, em;
    logic [6:0] addrs[3];
    logic       rws[3];
    addrs[0] = 7'h5B; rws[0] = 1'b0;
    addrs[1] = ADDR;  rws[1] = 1'b1;
    addrs[2] = ADDR ^ 7'($urandom_range(1, 127)); rws[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = '{8'($urandom)};
      i2c_xfer(addrs[i], rws[i], 1'b1, ka, ea, gm, em);
      vectors++; if (ka !== 1'b0 || ka !== ea) begin miscompares++; $display("FAIL bad_addr_ack[%0d]: got %b want 0", i, ka); end
      vectors++; if (gm !== em) begin miscompares++; $display("FAIL bad_addr_data_ack[%0d]: got %h want %h", i, gm, em); end
    end
    repeat (11*CPB) @(negedge clk);
    vectors++; if (mon_starts != tot_accepted || rx_raw_q.size() != 0) begin miscompares++; $display("FAIL bad_addr_uart: got %0d frames want 0", rx_raw_q.size()); end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  task automatic test_overflow();
    logic       ka, ea;
    logic [7:0] gm, em;
    bit         to;
    wr_data.delete();
    for (int i = 0; i < DEPTH + 2; i++) wr_data.push_back(8'($urandom));
    i2c_xfer(ADDR, 1'b0, 1'b1, ka, ea, gm, em);
    vectors++; if (ka !== 1'b1) begin miscompares++; $display("FAIL ovf_addr_ack: got %b want 1", ka); end
    vectors++; if (gm !== em) begin miscompares++; $display("FAIL ovf_model_acks: got %h want %h", gm, em); end
    vectors++; if (gm !== 8'h1F) begin miscompares++; $display("FAIL ovf_acks: got %h want 1f", gm); end
    wait_frames(to);
    vectors++; if (to || rx_raw_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ovf_count: got %0d want %0d", rx_raw_q.size(), exp_q.size()); end
    vectors++; if (mon_starts != tot_accepted) begin miscompares++; $display("FAIL ovf_frames: got %0d want %0d", mon_starts, tot_accepted); end
    for (int i = 0; i < exp_q.size() && i < rx_raw_q.size(); i++) begin
      vectors++; if (rx_raw_q[i] !== {1'b1, exp_q[i], 1'b0}) begin miscompares++; $display("FAIL ovf_data[%0d]: got %b want %b", i, rx_raw_q[i], {1'b1, exp_q[i], 1'b0}); end
    end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  task automatic test_interrupted();
    logic       ka, ea, k;
    logic [7:0] gm, em, a;
    bit         to;
    a = {ADDR, 1'b0};
    for (int pass = 0; pass < 2; pass++) begin
      i2c_start();
      for (int i = 7; i >= 0; i--) i2c_bit(a[i]);
      i2c_ack(k);
      vectors++; if (k !== 1'b1) begin miscompares++; $display("FAIL intr_partial_addr_ack[%0d]: got %b want 1", pass, k); end
      for (int i = 0; i < 4 - pass; i++) i2c_bit(1'($urandom));
      if (pass == 0) i2c_stop();
      wr_data = (pass == 0) ? '{8'hA5} : '{8'h5A};
      i2c_xfer(ADDR, 1'b0, 1'b1, ka, ea, gm, em);
      vectors++; if (ka !== 1'b1 || gm !== 8'h01 || gm !== em) begin miscompares++; $display("FAIL intr_acks[%0d]: got %b/%h want 1/01", pass, ka, gm); end
    end
    wait_frames(to);
    vectors++; if (to || rx_raw_q.size() != exp_q.size()) begin miscompares++; $display("FAIL intr_count: got %0d want %0d", rx_raw_q.size(), exp_q.size()); end
    vectors++; if (mon_starts != tot_accepted) begin miscompares++; $display("FAIL intr_frames: got %0d want %0d", mon_starts, tot_accepted); end
    for (int i = 0; i < exp_q.size() && i < rx_raw_q.size(); i++) begin
      vectors++; if (rx_raw_q[i] !== {1'b1, exp_q[i], 1'b0}) begin miscompares++; $display("FAIL intr_data[%0d]: got %b want %b", i, rx_raw_q[i], {1'b1, exp_q[i], 1'b0}); end
    end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  task automatic test_random();
    logic       ka, ea, rw;
    logic [7:0] gm, em;
    logic [6:0] addr;
    bit         to;
    int         n;
    for (int it = 0; it < 3; it++) begin
      addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
      rw   = ($urandom_range(0, 4) == 0);
      n    = $urandom_range(1, 2);
      wr_data.delete();
      for (int i = 0; i < n; i++) wr_data.push_back(8'($urandom));
      i2c_xfer(addr, rw, 1'b1, ka, ea, gm, em);
      vectors++; if (ka !== ea || gm !== em) begin miscompares++; $display("FAIL rand_acks[%0d]: got %b/%h want %b/%h", it, ka, gm, ea, em); end
    end
    wait_frames(to);
    vectors++; if (to || rx_raw_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", rx_raw_q.size(), exp_q.size()); end
    vectors++; if (mon_starts != tot_accepted) begin miscompares++; $display("FAIL rand_frames: got %0d want %0d", mon_starts, tot_accepted); end
    for (int i = 0; i < exp_q.size() && i < rx_raw_q.size(); i++) begin
      vectors++; if (rx_raw_q[i] !== {1'b1, exp_q[i], 1'b0}) begin miscompares++; $display("FAIL rand_data[%0d]: got %b want %b", i, rx_raw_q[i], {1'b1, exp_q[i], 1'b0}); end
    end
    exp_q.delete(); rx_raw_q.delete(); rx_t_q.delete();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_sda_low = 1'b0;
    bus.i_SCL = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_addr();
    test_overflow();
    test_interrupted();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_uart_bridge.md
Name: i2c_uart_bridge

Overview:
- Write-only I2C slave feeding a UART transmitter; bridges bytes from an I2C master onto a serial TX line.
- SCL/SDA are oversampled on the system clock.
- Each byte written to the slave's 7-bit address is ACKed, queued in a small FIFO and sent as a UART 8N1 frame.
- Sits at the chip top between the I2C pads and the UART TX pad.

Parameters:
- I2C_ADDR, 7'h47, 7-bit slave address the block responds to.
- CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200).
- FIFO_DEPTH, 4, number of received bytes buffered ahead of the UART; power of 2.

Ports:
- i_clk, input, 1, system clock; frequency at least 10x SCL frequency.
- i_reset_n, input, 1, asynchronous active-low reset.
- i_SCL, input, 1, I2C clock from master (externally pulled up).
- io_SDA, inout, 1, I2C data, open-drain: block drives 0 or Z only, never 1.
- o_TX, output, 1, UART serial output, idle high.

Behaviour:
- Reset: FSM in IDLE, SDA released (Z), FIFO empty, o_TX=1, UART idle; all shift/bit counters cleared.
- SCL and SDA each pass through a 2-flop synchronizer, then a registered previous-value for edge detection.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are detected in any state.
- START, including a repeated START: go to ADDR, clear the bit counter, discard any partial byte.
- STOP: go to IDLE, release SDA, discard any partial byte.
- Bits are sampled on SCL rising edges, MSB first.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W). After the 8th bit:
    - If address == I2C_ADDR and R/W == 0, go to ADDR_ACK.
    - Otherwise go to IGNORE with SDA released (NACK).
  - ADDR_ACK: on the next SCL falling edge drive SDA low. Hold it through the 9th SCL high. Release on the following falling edge, then go to DATA.
  - DATA: shift 8 bits. After the 8th bit:
    - If the FIFO is not full, push the byte and go to DATA_ACK.
    - If the FIFO is full, drop the byte and go to IGNORE (NACK).
  - DATA_ACK: same drive timing as ADDR_ACK, then return to DATA for the next byte.
  - IGNORE: SDA released; wait for START or STOP.
- The FIFO push happens in the same cycle the 8th data bit is sampled.
- Write and read in the same cycle are both allowed; occupancy stays the same.
- UART TX is 8N1:
  - When idle and the FIFO is non-empty, pop one byte.
  - Send start bit 0, then data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles; frame is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames: the next start bit directly follows the previous stop bit when data is waiting.
- Asynchronous reset mid-frame or mid-transaction aborts immediately: o_TX=1, SDA released, FIFO cleared.
- Bytes are transmitted in received order; no reordering or duplication.

Test Plan:
- Reset: assert i_reset_n=0 mid-activity -> o_TX=1 and SDA=Z at once; no UART frame after release until new I2C data arrives.
- Single write (100 MHz clk, 100 kHz SCL, CLKS_PER_BIT=16 for sim): START, address 0x47, W, data 0x67, STOP.
  - ACK (SDA=0) on the 9th clock of the address and of the data byte.
  - o_TX emits 0,1,1,1,0,0,1,1,0,1 (start, 0x67 LSB first, stop).
- Burst: START, 0x47+W, data 0x67, 0x14, 0x1E, STOP -> three ACKs; three consecutive UART frames carrying 0x67, 0x14, 0x1E in order.
- Wrong address or read:
  - Address 0x5B+W -> no ACK, no UART output.
  - Address 0x47+R -> no ACK, no UART output.
- FIFO overflow, CLKS_PER_BIT large: write FIFO_DEPTH+2 bytes quickly.
  - Data bytes are ACKed while the FIFO has room (it starts draining once the UART pops the first byte).
  - The first byte arriving with the FIFO full is NACKed and dropped; the block ignores the rest until STOP.
  - UART outputs exactly the accepted bytes, in order.
- Interrupted transfer: STOP after 4 data bits, then repeated START with 0x47+W and data 0xA5.
  - Partial byte is discarded.
  - Only 0xA5 is transmitted.
